// File: rtl/rsa_pkg.sv
// Shared types and defaults for the modular-exponentiation sequencer and its
// Montgomery-multiplier handshake.
package rsa_pkg;

    localparam int WIDTH_DEF     = 2048;
    localparam int EXP_WIDTH_DEF = 2048;
    localparam int OPCNT_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_CONV_BASE,
        ST_CONV_ONE,
        ST_LOOP_SQ,
        ST_LOOP_MUL,
        ST_FROM_MONT,
        ST_DONE
    } top_state_e;

    typedef enum logic [1:0] {
        OP_CLR,
        OP_RUN,
        OP_CAP
    } op_state_e;

    function automatic logic [OPCNT_W-1:0] sat_inc(input logic [OPCNT_W-1:0] v);
        return (v == '1) ? v : v + OPCNT_W'(1);
    endfunction

endpackage

// File: rtl/mont_op_seq.sv
// One Montgomery multiplication: restart pulse, run until finish, capture.
// state  | meaning
// OP_CLR | idle; on go pulse mont_rst for one cycle
// OP_RUN | mont_enable high, waiting for mont_finish
// OP_CAP | result captured and offered to the caller for one cycle
module mont_op_seq
    import rsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             cap_valid,
    output logic [WIDTH-1:0] cap_data,
    output logic [WIDTH-1:0] mont_x,
    output logic [WIDTH-1:0] mont_y,
    output logic             mont_enable,
    output logic             mont_rst,
    input  logic             mont_finish,
    input  logic [WIDTH-1:0] mont_result
);

    op_state_e        state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             clr_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OP_CLR;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        clr_pulse   = 1'b0;
        mont_enable = 1'b0;
        cap_valid   = 1'b0;
        case (state_q)
            OP_CLR: begin
                if (go) begin
                    clr_pulse = 1'b1;
                    state_d   = OP_RUN;
                end
            end
            OP_RUN: begin
                mont_enable = 1'b1;
                if (mont_finish) begin
                    res_d   = mont_result;
                    state_d = OP_CAP;
                end
            end
            OP_CAP: begin
                cap_valid = 1'b1;
                state_d   = OP_CLR;
            end
            default: state_d = OP_CLR;
        endcase
    end

    // The caller holds x/y steady for the whole op, so they pass straight through.
    assign mont_x   = x;
    assign mont_y   = y;
    assign mont_rst = rst | clr_pulse;
    assign busy     = (state_q != OP_CLR);
    assign cap_data = res_q;

endmodule

// File: rtl/modexp_ctrl.sv
// base^exponent mod modulus via left-to-right square-and-multiply on one
// shared Montgomery multiplier.
// state        | meaning
// ST_IDLE      | waiting for start; operands captured on accept
// ST_SCAN      | shift exponent until its MSB is set (find top bit k)
// ST_CONV_BASE | a_bar = MONT(base, r2)
// ST_CONV_ONE  | acc = MONT(1, r2)
// ST_LOOP_SQ   | acc = MONT(acc, acc) for the current bit
// ST_LOOP_MUL  | acc = MONT(acc, a_bar) when the current bit is 1
// ST_FROM_MONT | result = MONT(acc, 1)
// ST_DONE      | one-cycle done pulse
module modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int EXP_WIDTH = EXP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [WIDTH-1:0]     modulus,
    input  logic [WIDTH-1:0]     r2,
    input  logic [EXP_WIDTH-1:0] exponent,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [OPCNT_W-1:0]   op_count,
    output logic [WIDTH-1:0]     mont_x,
    output logic [WIDTH-1:0]     mont_y,
    output logic [WIDTH-1:0]     mont_n,
    output logic                 mont_enable,
    output logic                 mont_rst,
    input  logic                 mont_finish,
    input  logic [WIDTH-1:0]     mont_result
);

    localparam int CW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    top_state_e           state_q, state_d;
    logic [WIDTH-1:0]     base_q, base_d, r2_q, r2_d, mod_q, mod_d;
    logic [WIDTH-1:0]     acc_q, acc_d, abar_q, abar_d, result_q, result_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 zero_q, zero_d;
    logic [OPCNT_W-1:0]   opcnt_q, opcnt_d;

    logic                 in_op, go, seq_busy, cap_valid;
    logic [WIDTH-1:0]     cap_data, op_x, op_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            r2_q     <= '0;
            mod_q    <= '0;
            acc_q    <= '0;
            abar_q   <= '0;
            result_q <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
            opcnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            r2_q     <= r2_d;
            mod_q    <= mod_d;
            acc_q    <= acc_d;
            abar_q   <= abar_d;
            result_q <= result_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            zero_q   <= zero_d;
            opcnt_q  <= opcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        r2_d     = r2_q;
        mod_d    = mod_q;
        acc_d    = acc_q;
        abar_d   = abar_q;
        result_d = result_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        opcnt_d  = opcnt_q;
        in_op    = 1'b0;
        op_x     = '0;
        op_y     = '0;

        if (cap_valid) begin
            opcnt_d = sat_inc(opcnt_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base;
                    r2_d    = r2;
                    mod_d   = modulus;
                    exp_d   = exponent;
                    cnt_d   = '0;
                    zero_d  = 1'b0;
                    opcnt_d = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // cnt_q counts shifts so far; on exit it is reloaded with k.
                if (exp_q[EXP_WIDTH-1]) begin
                    cnt_d   = CW'(EXP_WIDTH - 1) - cnt_q;
                    state_d = ST_CONV_BASE;
                end else if (cnt_q == CW'(EXP_WIDTH - 1)) begin
                    zero_d  = 1'b1;
                    state_d = ST_CONV_BASE;
                end else begin
                    exp_d = exp_q << 1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_CONV_BASE: begin
                in_op = 1'b1;
                op_x  = base_q;
                op_y  = r2_q;
                if (cap_valid) begin
                    abar_d  = cap_data;
                    state_d = ST_CONV_ONE;
                end
            end
            ST_CONV_ONE: begin
                in_op = 1'b1;
                op_x  = ONE;
                op_y  = r2_q;
                if (cap_valid) begin
                    acc_d   = cap_data;
                    state_d = zero_q ? ST_FROM_MONT : ST_LOOP_SQ;
                end
            end
            ST_LOOP_SQ: begin
                in_op = 1'b1;
                op_x  = acc_q;
                op_y  = acc_q;
                if (cap_valid) begin
                    acc_d = cap_data;
                    if (exp_q[EXP_WIDTH-1]) begin
                        state_d = ST_LOOP_MUL;
                    end else if (cnt_q == '0) begin
                        state_d = ST_FROM_MONT;
                    end else begin
                        exp_d = exp_q << 1;
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            ST_LOOP_MUL: begin
                in_op = 1'b1;
                op_x  = acc_q;
                op_y  = abar_q;
                if (cap_valid) begin
                    acc_d = cap_data;
                    if (cnt_q == '0) begin
                        state_d = ST_FROM_MONT;
                    end else begin
                        exp_d   = exp_q << 1;
                        cnt_d   = cnt_q - CW'(1);
                        state_d = ST_LOOP_SQ;
                    end
                end
            end
            ST_FROM_MONT: begin
                in_op = 1'b1;
                op_x  = acc_q;
                op_y  = ONE;
                if (cap_valid) begin
                    result_d = cap_data;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request a new op only while the sequencer is idle; back-to-back ops
    // start the cycle after the previous capture.
    assign go = in_op & ~seq_busy;

    mont_op_seq #(.WIDTH(WIDTH)) u_op_seq (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .x           (op_x),
        .y           (op_y),
        .busy        (seq_busy),
        .cap_valid   (cap_valid),
        .cap_data    (cap_data),
        .mont_x      (mont_x),
        .mont_y      (mont_y),
        .mont_enable (mont_enable),
        .mont_rst    (mont_rst),
        .mont_finish (mont_finish),
        .mont_result (mont_result)
    );

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign op_count = opcnt_q;
    assign mont_n   = mod_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl with a behavioural Montgomery multiplier of
// configurable latency and a plain-arithmetic modexp reference.
module tb_modexp_ctrl;

    localparam int W  = 16;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  base = '0, modulus = '0, r2 = '0;
    logic [EW-1:0] exponent = '0;
    logic          busy, done;
    logic [W-1:0]  result;
    logic [15:0]   op_count;
    logic [W-1:0]  mont_x, mont_y, mont_n;
    logic          mont_enable, mont_rst, mont_finish;
    logic [W-1:0]  mont_result;

    int checks = 0;
    int failures = 0;

    modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .base(base), .modulus(modulus), .r2(r2), .exponent(exponent),
        .busy(busy), .done(done), .result(result), .op_count(op_count),
        .mont_x(mont_x), .mont_y(mont_y), .mont_n(mont_n),
        .mont_enable(mont_enable), .mont_rst(mont_rst),
        .mont_finish(mont_finish), .mont_result(mont_result)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: finish in the lm-th enabled cycle; optional
    // spurious finish while not enabled.
    int   lm = 1;
    bit   noise_en = 1'b0;
    int   mcnt = 0;
    logic noise = 1'b0;

    always @(posedge clk) begin
        if (mont_rst) mcnt <= 0;
        else if (mont_enable) mcnt <= mcnt + 1;
    end
    always @(negedge clk) noise <= noise_en ? 1'($urandom_range(0, 1)) : 1'b0;

    function automatic logic [W-1:0] mont_ref(input logic [W-1:0] x, y, n);
        longint unsigned t;
        t = longint'(x) * longint'(y);
        for (int i = 0; i < W; i++) begin
            if (t[0]) t = t + longint'(n);
            t = t >> 1;
        end
        if (t >= longint'(n)) t = t - longint'(n);
        return t[W-1:0];
    endfunction

    assign mont_finish = (mont_enable && (mcnt + 1 >= lm)) || (!mont_enable && noise);
    assign mont_result = mont_ref(mont_x, mont_y, mont_n);

    function automatic logic [W-1:0] powmod(input logic [W-1:0] b, input logic [EW-1:0] e,
                                             input logic [W-1:0] n);
        longint unsigned r, bb;
        r  = 1 % longint'(n);
        bb = longint'(b) % longint'(n);
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * bb) % longint'(n);
            bb = (bb * bb) % longint'(n);
        end
        return r[W-1:0];
    endfunction

    // Monitors: operand stability under enable, restart pulse width, done pulses.
    logic [W-1:0] px = '0, py = '0, pn = '0;
    logic pen = 1'b0, prst_pulse = 1'b0;
    int stab_viol = 0, rst_viol = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (mont_enable && pen && (mont_x !== px || mont_y !== py || mont_n !== pn)) stab_viol++;
        if (mont_enable && mont_rst) rst_viol++;
        if (mont_rst && !rst && prst_pulse) rst_viol++;
        if (rst && !mont_rst) rst_viol++;
        if (done) done_cnt++;
        px = mont_x; py = mont_y; pn = mont_n; pen = mont_enable;
        prst_pulse = mont_rst && !rst;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic run_job(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] n,
                           input int L, input bit nz, input string tag,
                           output logic [W-1:0] res_o, output logic [15:0] ops_o);
        longint unsigned rm;
        int k, expops, explat, cyc;
        logic [W-1:0] expres;
        lm = L;
        noise_en = nz;
        rm = 65536 % longint'(n);
        k = -1;
        for (int i = 0; i < EW; i++) if (e[i]) k = i;
        expops = (e == 0) ? 3 : 3 + (k + 1) + $countones(e);
        explat = ((e == 0) ? EW : EW - k) + expops * (L + 2) + 1;
        expres = powmod(b, e, n);

        @(negedge clk);
        base = b; exponent = e; modulus = n; r2 = W'((rm * rm) % longint'(n));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, 64'(busy), 64'd1);
        check({tag, " opcount_cleared"}, 64'(op_count), 64'd0);
        // Later input changes must not affect the running job.
        base = W'($urandom); exponent = EW'($urandom); modulus = W'($urandom) | 1; r2 = W'($urandom);
        cyc = 1;
        while (!done && cyc < 20000) begin
            start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            cyc++;
        end
        check({tag, " done_within_bound"}, 64'(cyc < 20000), 64'd1);
        check({tag, " latency"}, 64'(cyc), 64'(explat));
        check({tag, " result"}, 64'(result), 64'(expres));
        check({tag, " op_count"}, 64'(op_count), 64'(expops));
        res_o = result;
        ops_o = op_count;
        start = 1'b1;            // lands in the DONE cycle: must be ignored
        @(negedge clk);
        start = 1'b0;
        check({tag, " done_one_cycle"}, 64'(done), 64'd0);
        check({tag, " idle_after_done"}, 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check({tag, " result_held"}, 64'(result), 64'(expres));
        check({tag, " still_idle"}, 64'(busy), 64'd0);
        noise_en = 1'b0;
    endtask

    logic [W-1:0]  got_res;
    logic [15:0]   got_ops;
    int            jobs_done = 0;
    int            wcyc;

    initial begin
        @(negedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset op_count", 64'(op_count), 64'd0);
        check("reset mont_enable", 64'(mont_enable), 64'd0);
        check("reset mont_xyn", {16'd0, mont_x, mont_y, mont_n}, 64'd0);
        check("reset mont_rst", 64'(mont_rst), 64'd1);
        @(negedge clk);
        #2 rst = 1'b0;

        run_job(16'd2, 16'd10, 16'hFFF1, 1, 1'b0, "pow2_10", got_res, got_ops);
        check("pow2_10 const result", 64'(got_res), 64'h0400);
        check("pow2_10 const ops", 64'(got_ops), 64'd9);
        jobs_done++;

        run_job(16'h1234, 16'd0, 16'hFFF1, 3, 1'b1, "exp0", got_res, got_ops);
        check("exp0 const result", 64'(got_res), 64'd1);
        check("exp0 const ops", 64'(got_ops), 64'd3);
        jobs_done++;

        run_job(16'd3, 16'hFFF0, 16'hFFF1, 1, 1'b0, "fermat_l1", got_res, got_ops);
        check("fermat_l1 const result", 64'(got_res), 64'd1);
        check("fermat_l1 const ops", 64'(got_ops), 64'd31);
        jobs_done++;

        run_job(16'd3, 16'hFFF0, 16'hFFF1, 37, 1'b1, "fermat_l37", got_res, got_ops);
        check("fermat_l37 const result", 64'(got_res), 64'd1);
        jobs_done++;

        run_job(16'd2, 16'd10, 16'hFFF1, 37, 1'b0, "pow2_10_l37", got_res, got_ops);
        check("pow2_10_l37 const result", 64'(got_res), 64'h0400);
        jobs_done++;

        run_job(16'd7, 16'h8000, 16'hFFF1, 2, 1'b0, "msb_only", got_res, got_ops);
        jobs_done++;
        run_job(16'd9, 16'h0001, 16'hFFF1, 2, 1'b0, "exp1", got_res, got_ops);
        jobs_done++;

        // Reset in LOOP_MUL: op_count==3 after the first square of bit 15.
        lm = 6;
        @(negedge clk);
        base = 16'd5; exponent = 16'hB5A3; modulus = 16'hFFF1; r2 = 16'h00E1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wcyc = 0;
        while (op_count != 16'd3 && wcyc < 2000) begin
            @(negedge clk);
            wcyc++;
        end
        check("midrst reached_loop_mul", 64'(op_count), 64'd3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst result", 64'(result), 64'd0);
        check("midrst op_count", 64'(op_count), 64'd0);
        check("midrst mont_enable", 64'(mont_enable), 64'd0);
        check("midrst mont_xyn", {16'd0, mont_x, mont_y, mont_n}, 64'd0);
        check("midrst mont_rst", 64'(mont_rst), 64'd1);
        @(negedge clk);
        #1;
        check("midrst mont_rst_held", 64'(mont_rst), 64'd1);
        @(negedge clk);
        #2 rst = 1'b0;

        run_job(16'd5, 16'hB5A3, 16'hFFF1, 4, 1'b1, "after_rst", got_res, got_ops);
        jobs_done++;

        for (int j = 0; j < 6; j++) begin
            logic [W-1:0]  n, b;
            logic [EW-1:0] e;
            n = W'($urandom_range(3, 65535)) | 16'd1;
            b = W'($urandom_range(0, int'(n) - 1));
            case (j)
                0:       e = '0;
                1:       e = '1;
                default: e = EW'($urandom);
            endcase
            run_job(b, e, n, $urandom_range(1, 8), 1'($urandom_range(0, 1)),
                    $sformatf("rand%0d", j), got_res, got_ops);
            jobs_done++;
        end

        check("done_pulse_count", 64'(done_cnt), 64'(jobs_done));
        check("operand_stability", 64'(stab_viol), 64'd0);
        check("mont_rst_protocol", 64'(rst_viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Sequencer that computes result = base^exponent mod modulus by driving one shared Montgomery multiplier (MONT_TOP) through domain conversion, left-to-right square-and-multiply, and conversion back. It sits directly above MONT_TOP in the RSA datapath, owning its operand muxes, restart pulse and enable. Software or a top-level FSM supplies the precomputed constant R2 = R^2 mod modulus, with R = 2^WIDTH.

## Interface
- WIDTH, 2048: operand/modulus width; R = 2^WIDTH
- EXP_WIDTH, 2048: exponent width
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- base, modulus, r2  in  WIDTH  operands; r2 = R^2 mod modulus; base < modulus; modulus odd
- exponent  in  EXP_WIDTH  exponent
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result valid from this cycle
- result  out  WIDTH  final value, held until the next accepted start
- op_count  out  16  multiplier operations issued in the current/last job
- mont_x, mont_y, mont_n  out  WIDTH  multiplier operands
- mont_enable  out  1  multiplier run
- mont_rst  out  1  multiplier restart
- mont_finish  in  1  multiplier completion (level)
- mont_result  in  WIDTH  multiplier output MONT(x,y) = x·y·R^-1 mod n

## Operation
- Inputs base/exponent/modulus/r2 are captured into internal registers on the accepted start; later input changes have no effect on the running job.
- Top FSM: IDLE -> SCAN -> CONV_BASE -> CONV_ONE -> LOOP_SQ -> (LOOP_MUL) -> ... -> FROM_MONT -> DONE -> IDLE.
- SCAN: shift the exponent copy left one bit per cycle until its MSB is 1; record k = index of the top set bit. If exponent == 0, flag zero_exp and leave SCAN after EXP_WIDTH cycles.
- CONV_BASE: a_bar = MONT(base, r2). CONV_ONE: acc = MONT(1, r2) (= R mod n).
- For bit i = k down to 0: LOOP_SQ acc = MONT(acc, acc); if bit i = 1, LOOP_MUL acc = MONT(acc, a_bar). zero_exp skips the loop entirely.
- FROM_MONT: result = MONT(acc, 1). DONE: pulse done, return to IDLE.
- mont_n = captured modulus for the whole job.
- Each multiplier op (op sub-FSM OP_CLR -> OP_RUN -> OP_CAP):
  - OP_CLR: mont_rst = 1 for exactly one cycle, operands driven.
  - OP_RUN: mont_enable = 1, operands stable; wait for mont_finish.
  - OP_CAP: register mont_result into the destination, mont_enable = 0, increment op_count.
- op_count = 3 + (k+1) + popcount(exponent); 3 when exponent == 0. Clears on accepted start, saturates at 0xFFFF.
- start while busy: ignored, no queuing. start in the DONE cycle: ignored.

## Timing
- Reset values: busy 0, done 0, result 0, op_count 0, mont_enable 0, mont_x/y/n 0, FSMs in IDLE/OP_CLR. mont_rst = rst OR the OP_CLR pulse, so the multiplier is held in reset whenever rst is high.
- Reset mid-job: aborts immediately; all outputs return to reset values; no done pulse.
- Start accepted at edge t: busy = 1 from t+1.
- Op cost = L_m + 2 cycles, where L_m is the number of cycles mont_enable is high before mont_finish is seen.
- Total latency from accepted start to done = SCAN cycles + op_count·(L_m + 2) + 1.
  - SCAN cycles = EXP_WIDTH − 1 − k + 1, or EXP_WIDTH when exponent == 0.
- mont_finish asserted outside OP_RUN: ignored.
- Operands never change while mont_enable = 1.

## Structure
- Shared package rsa_pkg: WIDTH/EXP_WIDTH defaults, top-FSM and op-FSM state encodings, op_count width.
- Sub-module mont_op_seq: the OP_CLR/RUN/CAP handshake. Ports: go, x, y; outputs busy, cap_valid, cap_data; the MONT_TOP side signals.
- modexp_ctrl contains the top FSM, exponent shifter, and acc/a_bar registers.
- The bench instantiates MONT_TOP or a parameterisable behavioral Montgomery model with configurable L_m.

## Test plan
- WIDTH=16, modulus=0xFFF1, r2=0x00E1, base=2, exponent=10 -> result 0x0400, op_count 9, one done pulse.
- Same modulus, exponent=0, base=0x1234 -> result 1, op_count 3, SCAN takes EXP_WIDTH cycles.
- Same modulus, base=3, exponent=0xFFF0 -> result 1 (Fermat), op_count 3+16+12=31.
- Model with L_m = 1 and L_m = 37 -> identical results; latency matches the formula exactly; operands stable throughout mont_enable.
- rst asserted during LOOP_MUL -> all outputs return to reset values in the same cycle; mont_rst high while rst is high; a following start completes correctly.
- start pulsed while busy and in the DONE cycle -> ignored; result held unchanged until the next accepted start.
